// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Optional pending-write bypass: WB_STAGE_FWD_EN.
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        WAIT_LD,
        COMMIT
    } wb_state_t;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;
    localparam logic [1:0] LD_FULL = 2'd3;

    localparam int LINK_REG_DEF = 31;

endpackage

// File: rtl/wb_load_align.sv
// Load data lane select and sign/zero extension.
// Combinational; size LD_FULL passes the raw word through.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            ld_data,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    output logic [DATA_W-1:0]            result
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam logic [OFF_W-1:0] MASK_H = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] MASK_W = ~OFF_W'(3);

    logic [OFF_W-1:0] lane;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;

    always_comb begin
        lane = offset;
        unique case (1'b1)
            size == LD_HALF: lane = offset & MASK_H;
            size == LD_WORD: lane = offset & MASK_W;
            default:         lane = offset;
        endcase

        b = 8'(ld_data >> {lane, 3'b000});
        h = 16'(ld_data >> {lane, 3'b000});
        w = 32'(ld_data >> {lane, 3'b000});

        result = ld_data;
        unique case (1'b1)
            size == LD_BYTE:
                result = is_unsigned ? DATA_W'(b) : DATA_W'($signed(b));
            size == LD_HALF:
                result = is_unsigned ? DATA_W'(h) : DATA_W'($signed(h));
            size == LD_WORD:
                result = is_unsigned ? DATA_W'(w) : DATA_W'($signed(w));
            default:
                result = ld_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// MEM/WB register plus writeback select with load-response wait.
// Define WB_STAGE_FWD_EN to enable the pending-write bypass port.
module wb_stage_pipelined
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 5,
    parameter int RA_W     = 5,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int PC_INC   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mem_to_reg,
    input  logic                         in_jal,
    input  logic                         in_reg_write,
    input  logic [RA_W-1:0]              in_rd,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [DATA_W-1:0]            in_alu,
    input  logic [1:0]                   in_ld_size,
    input  logic                         in_ld_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  in_addr_lo,
    input  logic                         ld_data_valid,
    input  logic [DATA_W-1:0]            ld_data,
    output logic                         rf_we,
    output logic [RA_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         busy,
    output logic                         fwd_valid,
    output logic [RA_W-1:0]              fwd_rd,
    output logic [DATA_W-1:0]            fwd_data
);

    localparam int OFF_W = $clog2(DATA_W/8);

    wb_state_t state, next_state;

    logic              accept;
    logic              is_load;
    logic [RA_W-1:0]   final_rd;
    logic [DATA_W-1:0] link_val;
    logic [DATA_W-1:0] ld_aligned;

    logic [RA_W-1:0]   rd_q;
    logic              rw_q;
    logic [1:0]        sz_q;
    logic              uns_q;
    logic [OFF_W-1:0]  off_q;

    assign in_ready = (state != WAIT_LD);
    assign busy     = (state == WAIT_LD);
    assign accept   = in_valid && in_ready;
    assign is_load  = in_mem_to_reg && !in_jal;
    assign final_rd = in_jal ? RA_W'(LINK_REG) : in_rd;
    assign link_val = DATA_W'(in_pc) + DATA_W'(PC_INC);

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .ld_data     (ld_data),
        .size        (sz_q),
        .is_unsigned (uns_q),
        .offset      (off_q),
        .result      (ld_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            WAIT_LD:
                if (ld_data_valid) next_state = COMMIT;
            default:
                if (accept) next_state = is_load ? WAIT_LD : COMMIT;
                else        next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            sz_q     <= LD_BYTE;
            uns_q    <= 1'b0;
            off_q    <= '0;
        end else begin
            rf_we <= 1'b0;
            if (accept) begin
                rd_q  <= final_rd;
                rw_q  <= in_reg_write;
                sz_q  <= in_ld_size;
                uns_q <= in_ld_unsigned;
                off_q <= in_addr_lo;
                if (!is_load) begin
                    rf_we    <= in_reg_write && (final_rd != '0);
                    rf_waddr <= final_rd;
                    rf_wdata <= in_jal ? link_val : in_alu;
                end
            end else if (state == WAIT_LD && ld_data_valid) begin
                rf_we    <= rw_q && (rd_q != '0);
                rf_waddr <= rd_q;
                rf_wdata <= ld_aligned;
            end
        end
    end

`ifdef WB_STAGE_FWD_EN
    // Data is not known until the load returns, so only COMMIT may bypass.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        unique case (state)
            WAIT_LD: fwd_rd = rd_q;
            COMMIT: begin
                fwd_valid = rf_we;
                fwd_rd    = rf_waddr;
                fwd_data  = rf_wdata;
            end
            default: ;
        endcase
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule
